interrupt_sequencer: RTL

- Controls the pipeline for one external interrupt line. It samples and latches the request, waits for a safe instruction boundary, then freezes fetch and flushes the younger instructions.
- It then injects the PC-push and flags-push micro-ops into the decode/EXM buffer and redirects fetch to the interrupt vector.
- Sits beside fetch_stage and decode_stage. It replaces the constant-0 interrupt inputs on fetch_stage, decode_stage and decode_exm_buffer.

---
 rtl/cpu_pkg.sv | 22 ++
 rtl/sync_edge_detect.sv | 31 +++
 rtl/interrupt_sequencer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the interrupt sequencer
// Contents:
//   state_t             interrupt sequencer FSM states
//   DEFAULT_VECTOR_ADDR memory word that holds the ISR address
//   UOP_PUSH_PC         micro-op code decode injects for the PC push
//   UOP_PUSH_FLAGS      micro-op code decode injects for the flags push
package cpu_pkg;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    DRAIN      = 3'd1,
    PUSH_PC    = 3'd2,
    PUSH_FLAGS = 3'd3,
    LOAD_VEC   = 3'd4
  } state_t;

  localparam logic [15:0] DEFAULT_VECTOR_ADDR = 16'h0000;

  localparam logic [7:0] UOP_PUSH_PC    = 8'hF1;
  localparam logic [7:0] UOP_PUSH_FLAGS = 8'hF2;

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - multi-flop synchronizer followed by a rising-edge detector
// Ports:
//   i_clk    clock
//   i_reset  asynchronous active-low reset
//   i_async  asynchronous level input
//   o_rise   one-cycle pulse when the synchronized level goes 0 -> 1
module sync_edge_detect #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_async,
  output logic o_rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;

endmodule

// File: rtl/interrupt_sequencer.sv
// rtl/interrupt_sequencer.sv - sequences interrupt entry: drain, push PC, push flags, load vector
// Ports:
//   i_clk, i_reset      clock, asynchronous active-low reset
//   i_interrupt         asynchronous level request, rising edge = one request
//   i_imm_pending       decode is between the two words of an immediate instruction
//   i_branch_taken      EXM redirects the PC this cycle
//   i_rti               RTI retiring in EXM
//   o_stall_fetch       hold PC and fetch_decode_buffer
//   o_flush_decode      fetch_decode_buffer outputs a NOP
//   o_push_pc           inject push-PC micro-op
//   o_push_flags        inject push-flags micro-op
//   o_load_vector       fetch loads PC from mem[o_vector_addr]
//   o_vector_addr       constant VECTOR_ADDR
//   o_in_isr            an ISR is active
//   o_busy              sequence in progress
module interrupt_sequencer
  import cpu_pkg::*;
#(
  parameter int          SYNC_STAGES  = 2,
  parameter int          DRAIN_CYCLES = 2,
  parameter logic [15:0] VECTOR_ADDR  = DEFAULT_VECTOR_ADDR
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_interrupt,
  input  logic        i_imm_pending,
  input  logic        i_branch_taken,
  input  logic        i_rti,
  output logic        o_stall_fetch,
  output logic        o_flush_decode,
  output logic        o_push_pc,
  output logic        o_push_flags,
  output logic        o_load_vector,
  output logic [15:0] o_vector_addr,
  output logic        o_in_isr,
  output logic        o_busy
);

  localparam int CNT_W = 8;

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_count;
  logic             r_pending;
  logic             r_in_isr;
  logic             w_rise;
  logic             w_start;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_async (i_interrupt),
    .o_rise  (w_rise)
  );

  // A fresh edge can start the sequence in the same cycle it is detected,
  // so the first stall appears one cycle after the synchronized edge.
  assign w_start = (r_state == IDLE) && (r_pending || w_rise) && !r_in_isr &&
                   !i_imm_pending && !i_branch_taken;

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_pending <= 1'b0;
      r_count   <= '0;
      r_in_isr  <= 1'b0;
    end else begin
      // On the start cycle the request being served is consumed; an edge
      // arriving while an older request was already pending survives.
      if (w_start) begin
        r_pending <= r_pending & w_rise;
      end else if (w_rise) begin
        r_pending <= 1'b1;
      end

      if (w_start) begin
        r_count <= CNT_W'(DRAIN_CYCLES - 1);
      end else if (r_state == DRAIN && r_count != '0) begin
        r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
      end

      if (r_state == LOAD_VEC) begin
        r_in_isr <= 1'b1;
      end else if (i_rti && r_in_isr) begin
        r_in_isr <= 1'b0;
      end
    end
  end

  always_comb begin
    w_next         = r_state;
    o_stall_fetch  = 1'b0;
    o_flush_decode = 1'b0;
    o_push_pc      = 1'b0;
    o_push_flags   = 1'b0;
    o_load_vector  = 1'b0;
    o_busy         = 1'b1;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (w_start) w_next = DRAIN;
      end
      DRAIN: begin
        o_stall_fetch  = 1'b1;
        o_flush_decode = 1'b1;
        if (r_count == '0) w_next = PUSH_PC;
      end
      PUSH_PC: begin
        o_stall_fetch = 1'b1;
        o_push_pc     = 1'b1;
        w_next        = PUSH_FLAGS;
      end
      PUSH_FLAGS: begin
        o_stall_fetch = 1'b1;
        o_push_flags  = 1'b1;
        w_next        = LOAD_VEC;
      end
      LOAD_VEC: begin
        o_load_vector  = 1'b1;
        o_flush_decode = 1'b1;
        w_next         = IDLE;
      end
      default: begin
        o_busy = 1'b0;
        w_next = IDLE;
      end
    endcase
  end

  assign o_vector_addr = VECTOR_ADDR;
  assign o_in_isr      = r_in_isr;

endmodule
